// File: rtl/nes_controller_reader.sv
// nes_controller_reader
//   Polls one NES game controller over its latch/pulse/data serial link and
//   presents the eight buttons as an active-high byte:
//     [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//   A scan starts every POLL_CYCLES clocks:
//     latch high for LATCH_CYCLES clocks,
//     a HALF_CYCLES gap in which bit 0 is sampled,
//     then 7 pulses (HALF_CYCLES high, HALF_CYCLES low) that sample bits 1..7.
//   buttons_valid strobes for one cycle, in the same cycle that nes_buttons
//   takes the new value.
//   Optional build macro NES_DEBOUNCE_EN: nes_buttons only updates when two
//   consecutive scans return the same raw byte.
module nes_controller_reader #(
  parameter int LATCH_CYCLES = 1200,
  parameter int HALF_CYCLES  = 600,
  parameter int POLL_CYCLES  = 1666667
) (
  input  logic       sysclk,
  input  logic       reset_high,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_pulse,
  output logic [7:0] nes_buttons,
  output logic       buttons_valid
);

  localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_GAP,
    S_PULSE_HI,
    S_PULSE_LO,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [POLL_W-1:0]   r_poll;
  logic [PH_W-1:0]     r_phase;
  logic [2:0]          r_idx;
  logic [7:0]          r_shift;
  logic [7:0]          r_buttons;
  logic                r_sync1;
  logic                r_sync2;
  logic                r_latch;
  logic                r_pulse;
  logic                r_valid;
  logic                w_poll_wrap;
  logic                w_phase_last;
  logic                w_sample;

`ifdef NES_DEBOUNCE_EN
  logic [7:0]          r_prev_raw;
`endif

  assign nes_latch     = r_latch;
  assign nes_pulse     = r_pulse;
  assign nes_buttons   = r_buttons;
  assign buttons_valid = r_valid;

  assign w_poll_wrap  = (r_poll == POLL_W'(POLL_CYCLES - 1));

  // The latch phase has its own length; the gap and both pulse halves share HALF_CYCLES.
  assign w_phase_last = (r_state == S_LATCH) ? (r_phase == PH_W'(LATCH_CYCLES - 1))
                                             : (r_phase == PH_W'(HALF_CYCLES - 1));

  // Two-flop synchroniser for the asynchronous data line. It resets high so that
  // an idle line reads as "not pressed".
  always_ff @(posedge sysclk or posedge reset_high) begin
    if (reset_high) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. r_sync2 must
      // capture the old value of r_sync1, not the value updated in this cycle.
      r_sync1 <= nes_data;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running poll counter. It wraps every POLL_CYCLES cycles.
  always_ff @(posedge sysclk or posedge reset_high) begin
    if (reset_high) begin
      r_poll <= '0;
    end else if (w_poll_wrap) begin
      r_poll <= '0;
    end else begin
      r_poll <= r_poll + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge sysclk or posedge reset_high) begin
    if (reset_high) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and sample strobe.
  // A poll wrap that arrives outside IDLE is dropped.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // can leave it unassigned and infer a latch.
    w_state_next = r_state;
    w_sample     = 1'b0;
    unique case (r_state)
      S_IDLE:     if (w_poll_wrap)  w_state_next = S_LATCH;
      S_LATCH:    if (w_phase_last) w_state_next = S_GAP;
      S_GAP: begin
        if (w_phase_last) begin
          w_sample     = 1'b1;
          w_state_next = S_PULSE_HI;
        end
      end
      S_PULSE_HI: if (w_phase_last) w_state_next = S_PULSE_LO;
      S_PULSE_LO: begin
        if (w_phase_last) begin
          w_sample     = 1'b1;
          w_state_next = (r_idx == 3'd7) ? S_DONE : S_PULSE_HI;
        end
      end
      S_DONE:     w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // Phase timer. It restarts on every state change and stays at 0 while IDLE.
  always_ff @(posedge sysclk or posedge reset_high) begin
    if (reset_high) begin
      r_phase <= '0;
    end else if ((w_state_next != r_state) || (r_state == S_IDLE)) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

  // Registered pin outputs, decoded from the next state so they change with it.
  // The valid strobe is registered from DONE, so it lines up with the
  // nes_buttons update.
  always_ff @(posedge sysclk or posedge reset_high) begin
    if (reset_high) begin
      r_latch <= 1'b0;
      r_pulse <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_latch <= (w_state_next == S_LATCH);
      r_pulse <= (w_state_next == S_PULSE_HI);
      r_valid <= (r_state == S_DONE);
    end
  end

  // Serial capture: raw (active-low) bits go into r_shift[r_idx].
  // The 3-bit index wraps back to 0 after bit 7.
  always_ff @(posedge sysclk or posedge reset_high) begin
    if (reset_high) begin
      r_shift <= 8'h00;
      r_idx   <= 3'd0;
    end else if (w_sample) begin
      r_shift[r_idx] <= r_sync2;
      r_idx          <= r_idx + 3'd1;
    end
  end

  // Parallel output update. It happens only in DONE, so a scan cut short by
  // reset never reaches nes_buttons.
`ifdef NES_DEBOUNCE_EN
  always_ff @(posedge sysclk or posedge reset_high) begin
    if (reset_high) begin
      r_buttons  <= 8'h00;
      r_prev_raw <= 8'h00;
    end else if (r_state == S_DONE) begin
      if (r_shift == r_prev_raw) begin
        r_buttons <= ~r_shift;
      end
      r_prev_raw <= r_shift;
    end
  end
`else
  always_ff @(posedge sysclk or posedge reset_high) begin
    if (reset_high) begin
      r_buttons <= 8'h00;
    end else if (r_state == S_DONE) begin
      r_buttons <= ~r_shift;
    end
  end
`endif

endmodule

// File: tb/tb_nes_controller_reader.sv
// tb_nes_controller_reader
//   Directed bench for nes_controller_reader, run with short timing:
//     LATCH_CYCLES=4, HALF_CYCLES=2, POLL_CYCLES=64 (SCAN_LEN=34).
//   A behavioural 4021-style controller drives nes_data from a "pressed" byte.
//   A small reference model predicts nes_buttons, including the debounce rule
//   when NES_DEBOUNCE_EN is defined.
module tb_nes_controller_reader;

  localparam int LATCH_CYCLES = 4;
  localparam int HALF_CYCLES  = 2;
  localparam int POLL_CYCLES  = 64;
  localparam int SCAN_LEN     = LATCH_CYCLES + HALF_CYCLES + 7 * 2 * HALF_CYCLES;

  logic       sysclk = 1'b0;
  logic       reset_high;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_pulse;
  logic [7:0] nes_buttons;
  logic       buttons_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Controller model: 0 = shift register, 1 = line stuck high, 2 = line stuck low.
  int         data_mode = 1;
  logic [7:0] pressed   = 8'h00;
  logic [7:0] ctrl_sh   = 8'hFF;

  // Reference model of the output byte.
  logic [7:0] m_btn  = 8'h00;
  logic [7:0] m_prev = 8'h00;

  // Monitor state, sampled on the falling edge.
  int   cyc      = 0;
  int   lat_rise = 0;
  int   lat_hi   = 0;
  int   p_cnt    = 0;
  int   ph_run   = 0;
  int   pl_run   = 0;
  int   pw_err   = 0;
  int   both_err = 0;
  int   v_err    = 0;
  int   v_cnt    = 0;
  int   v_cyc    = 0;
  logic prev_l   = 1'b0;
  logic prev_p   = 1'b0;
  logic prev_v   = 1'b0;

  nes_controller_reader #(
    .LATCH_CYCLES(LATCH_CYCLES),
    .HALF_CYCLES (HALF_CYCLES),
    .POLL_CYCLES (POLL_CYCLES)
  ) dut (
    .sysclk       (sysclk),
    .reset_high   (reset_high),
    .nes_data     (nes_data),
    .nes_latch    (nes_latch),
    .nes_pulse    (nes_pulse),
    .nes_buttons  (nes_buttons),
    .buttons_valid(buttons_valid)
  );

  always #5 sysclk = ~sysclk;

  // Controller: latch loads the active-low buttons; each pulse rise shifts the next bit out.
  always @(posedge nes_latch or posedge nes_pulse) begin
    if (nes_latch) ctrl_sh = ~pressed;
    else           ctrl_sh = {1'b1, ctrl_sh[7:1]};
  end

  assign nes_data = (data_mode == 1) ? 1'b1 :
                    (data_mode == 2) ? 1'b0 : ctrl_sh[0];

  // Cycle counter and per-scan waveform measurements.
  // cyc counts rising edges since reset release.
  always @(negedge sysclk) begin
    if (reset_high) begin
      cyc = 0; lat_rise = 0; lat_hi = 0; p_cnt = 0; ph_run = 0; pl_run = 0;
      prev_l = 1'b0; prev_p = 1'b0; prev_v = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (nes_latch && nes_pulse) both_err = both_err + 1;
      if (nes_latch && !prev_l) begin
        lat_rise = cyc;
        lat_hi   = 0;
        p_cnt    = 0;
      end
      if (nes_latch) lat_hi = lat_hi + 1;
      if (nes_pulse && !prev_p) begin
        p_cnt = p_cnt + 1;
        if (pl_run != HALF_CYCLES) pw_err = pw_err + 1;
        ph_run = 0;
      end
      if (!nes_pulse && prev_p) begin
        if (ph_run != HALF_CYCLES) pw_err = pw_err + 1;
        pl_run = 0;
      end
      if (nes_pulse) ph_run = ph_run + 1;
      if (nes_latch)       pl_run = 0;
      else if (!nes_pulse) pl_run = pl_run + 1;
      if (buttons_valid) begin
        if (prev_v) v_err = v_err + 1;
        v_cnt = v_cnt + 1;
        v_cyc = cyc;
      end
      prev_l = nes_latch;
      prev_p = nes_pulse;
      prev_v = buttons_valid;
    end
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected output after one scan that returns pressed-equivalent byte pr.
  task automatic model_scan(input logic [7:0] pr);
`ifdef NES_DEBOUNCE_EN
    if (~pr == m_prev) m_btn = pr;
    m_prev = ~pr;
`else
    m_btn = pr;
`endif
  endtask

  task automatic model_reset();
    m_btn  = 8'h00;
    m_prev = 8'h00;
  endtask

  task automatic wait_valid(output bit timed_out);
    int start;
    start     = v_cnt;
    timed_out = 1'b1;
    for (int i = 0; i < 4 * POLL_CYCLES; i++) begin
      @(negedge sysclk);
      #1;
      if (v_cnt != start) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // One full scan: update the model, wait for the strobe, check timing and the byte.
  task automatic scan_check(input string tag, input logic [7:0] pr, input bit timing);
    bit to;
    model_scan(pr);
    wait_valid(to);
    check({tag, "_timeout"}, to, 0);
    check({tag, "_buttons"}, nes_buttons, m_btn);
    if (timing) begin
      check({tag, "_latency"}, v_cyc - lat_rise, SCAN_LEN + 1);
      check({tag, "_latch_len"}, lat_hi, LATCH_CYCLES);
      check({tag, "_pulses"}, p_cnt, 7);
      check({tag, "_poll_phase"}, lat_rise % POLL_CYCLES, 0);
    end
  endtask

  task automatic release_reset();
    @(negedge sysclk);
    #1 reset_high = 1'b0;
    model_reset();
  endtask

  initial begin
    bit to;
    logic [7:0] r;

    // Reset values, checked while reset is held.
    reset_high = 1'b1;
    repeat (3) @(negedge sysclk);
    #1;
    check("rst_latch", nes_latch, 0);
    check("rst_pulse", nes_pulse, 0);
    check("rst_valid", buttons_valid, 0);
    check("rst_buttons", nes_buttons, 8'h00);
    release_reset();

    // 1: unplugged (line high) reads 00. The first latch rises 64 cycles after release.
    data_mode = 1;
    scan_check("t1", 8'h00, 1'b1);
    check("t1_first_latch", lat_rise, POLL_CYCLES);
    check("t1_pulse_width", pw_err, 0);

    // 2: A+Start+Left pressed, then A only. The byte holds between scans.
    data_mode = 0;
    pressed   = 8'b0100_1001;
    scan_check("t2a", pressed, 1'b1);
    pressed = 8'h01;
    scan_check("t2b", pressed, 1'b1);
    repeat (20) @(negedge sysclk);
    #1 check("t2_hold", nes_buttons, m_btn);

    // 3: reset during the third pulse. Outputs drop at once, and a clean scan follows.
    pressed = 8'h5A;
    to      = 1'b1;
    for (int i = 0; i < 4 * POLL_CYCLES; i++) begin
      @(negedge sysclk);
      #1;
      if (p_cnt == 3 && nes_pulse) begin
        to = 1'b0;
        break;
      end
    end
    check("t3_pulse3_timeout", to, 0);
    reset_high = 1'b1;
    #1;
    check("t3_latch", nes_latch, 0);
    check("t3_pulse", nes_pulse, 0);
    check("t3_valid", buttons_valid, 0);
    check("t3_buttons", nes_buttons, 8'h00);
    repeat (3) @(negedge sysclk);
    release_reset();
    pressed = 8'h22;
    scan_check("t3_resume", pressed, 1'b1);
    check("t3_first_latch", lat_rise, POLL_CYCLES);

    // 4: line stuck low reads FF, with exactly 7 pulses.
    data_mode = 2;
    scan_check("t4a", 8'hFF, 1'b1);
    scan_check("t4b", 8'hFF, 1'b1);
    check("t4_both_high", both_err, 0);

    // 5: Right pressed for one scan, then for two. The model applies debounce only when enabled.
    data_mode = 0;
    pressed = 8'h00; scan_check("t5_idle0", pressed, 1'b0);
    pressed = 8'h00; scan_check("t5_idle1", pressed, 1'b0);
    pressed = 8'h80; scan_check("t5_once", pressed, 1'b0);
    pressed = 8'h00; scan_check("t5_gone", pressed, 1'b0);
    pressed = 8'h80; scan_check("t5_first", pressed, 1'b0);
    pressed = 8'h80; scan_check("t5_second", pressed, 1'b1);

    // 6: random scans. Some bytes repeat so the debounce load path is exercised.
    for (int i = 0; i < 200; i++) begin
      r = 8'($urandom);
      if ((i % 3) != 0) pressed = r;
      scan_check("t6_rand", pressed, 1'b0);
    end

    // Invariants accumulated over the whole run.
    check("both_high", both_err, 0);
    check("valid_width", v_err, 0);
    check("pulse_width", pw_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
